// File: rtl/vga_hvsync_generator.sv
// vga_hvsync_generator: free-running VGA raster timing with registered sync,
// visible-area flag and beam coordinates (640x480@60 defaults).
module vga_hvsync_generator #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT = 16,
    parameter int H_SYNC = 96,
    parameter int H_BACK = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT = 10,
    parameter int V_SYNC = 2,
    parameter int V_BACK = 33,
    parameter logic HSYNC_ACTIVE = 1'b0,
    parameter logic VSYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly
    localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_END = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] VS_END = 11'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [10:0] H_VIS = 11'(H_DISPLAY);
    localparam logic [10:0] V_VIS = 11'(V_DISPLAY);

    logic [9:0] hpos_d, hpos_q, vpos_d, vpos_q;
    logic hsync_d, hsync_q, vsync_d, vsync_q, display_on_d, display_on_q;
    logic h_end, v_end;

    // Decode from next-state counters so outputs line up with the coordinates they describe
    always_comb begin
        h_end = hpos_q == 10'(H_TOTAL - 1);
        v_end = vpos_q == 10'(V_TOTAL - 1);
        hpos_d = (!reset || h_end) ? 10'd0 : hpos_q + 10'd1;
        vpos_d = !reset ? 10'd0 : !h_end ? vpos_q : v_end ? 10'd0 : vpos_q + 10'd1;
        hsync_d = ({1'b0, hpos_d} >= HS_START && {1'b0, hpos_d} < HS_END) ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
        vsync_d = ({1'b0, vpos_d} >= VS_START && {1'b0, vpos_d} < VS_END) ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
        display_on_d = ({1'b0, hpos_d} < H_VIS) && ({1'b0, vpos_d} < V_VIS);
    end

    always_ff @(posedge clk) begin
        hpos_q <= hpos_d;
        vpos_q <= vpos_d;
        hsync_q <= hsync_d;
        vsync_q <= vsync_d;
        display_on_q <= display_on_d;
    end

    assign hpos = hpos_q;
    assign vpos = vpos_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;
    assign display_on = display_on_q;
endmodule

// File: tb/tb_vga_hvsync_generator.sv
// tb_vga_hvsync_generator: directed vectors on a default 640x480 instance plus
// a cycle-by-cycle model of a tiny raster (15x10, active-high syncs) for frame-level checks.
module tb_vga_hvsync_generator;
    logic clk, reset;
    logic b_hs, b_vs, b_de, s_hs, s_vs, s_de;
    logic [9:0] b_hpos, b_vpos, s_hpos, s_vpos;

    vga_hvsync_generator dut_big (
        .clk(clk), .reset(reset), .hsync(b_hs), .vsync(b_vs),
        .display_on(b_de), .hpos(b_hpos), .vpos(b_vpos)
    );

    // Small raster: H 8+2+3+2=15 (hsync 10..12), V 6+1+2+1=10 (vsync lines 7..8)
    vga_hvsync_generator #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HSYNC_ACTIVE(1'b1), .VSYNC_ACTIVE(1'b1)
    ) dut_small (
        .clk(clk), .reset(reset), .hsync(s_hs), .vsync(s_vs),
        .display_on(s_de), .hpos(s_hpos), .vpos(s_vpos)
    );

    typedef struct {
        int n;
        logic [9:0] h;
        logic [9:0] v;
        logic hs;
        logic vs;
        logic de;
    } vec_t;

    vec_t vecs[12];
    int checks = 0, errors = 0;
    int n = 0;
    logic [9:0] mh, mv;
    bit started = 0;
    int flen, fde, fvs, frames = 0;
    int hs_cnt = 0, hs_first = -1, hs_last = -1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [22:0] act, input logic [22:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s n=%0d got h=%0d v=%0d hs/vs/de=%b want h=%0d v=%0d hs/vs/de=%b",
                     name, n, act[22:13], act[12:3], act[2:0], exp[22:13], exp[12:3], exp[2:0]);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        logic r;
        r = reset;
        @(posedge clk);
        #1;
        if (!r) begin
            mh = 0;
            mv = 0;
        end else if (mh == 14) begin
            mh = 0;
            mv = (mv == 9) ? 10'd0 : mv + 10'd1;
        end else mh = mh + 10'd1;
        chk("small_raster", {s_hpos, s_vpos, s_hs, s_vs, s_de},
            {mh, mv, mh >= 10 && mh < 13, mv >= 7 && mv < 9, mh < 8 && mv < 6});
        if (!r) started = 0;
        else if (s_hpos == 0 && s_vpos == 0) begin
            if (started) begin
                chk_int("small_frame_len", flen, 150);
                chk_int("small_display_cycles", fde, 48);
                chk_int("small_vsync_cycles", fvs, 30);
                frames++;
            end
            started = 1;
            flen = 0;
            fde = 0;
            fvs = 0;
        end
        if (started) begin
            flen++;
            fde += int'(s_de);
            fvs += int'(s_vs);
        end
        if (r && b_vpos == 2 && !b_hs) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(b_hpos);
            hs_last = int'(b_hpos);
        end
        n = r ? n + 1 : 0;
    endtask

    initial begin
        vecs[0]  = '{1,    1,   0, 1, 1, 1};
        vecs[1]  = '{639,  639, 0, 1, 1, 1};
        vecs[2]  = '{640,  640, 0, 1, 1, 0};
        vecs[3]  = '{655,  655, 0, 1, 1, 0};
        vecs[4]  = '{656,  656, 0, 0, 1, 0};
        vecs[5]  = '{751,  751, 0, 0, 1, 0};
        vecs[6]  = '{752,  752, 0, 1, 1, 0};
        vecs[7]  = '{799,  799, 0, 1, 1, 0};
        vecs[8]  = '{800,  0,   1, 1, 1, 1};
        vecs[9]  = '{1599, 799, 1, 1, 1, 0};
        vecs[10] = '{1600, 0,   2, 1, 1, 1};
        vecs[11] = '{1656, 56,  2, 1, 1, 1};

        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("big_in_reset", {b_hpos, b_vpos, b_hs, b_vs, b_de}, {10'd0, 10'd0, 3'b111});
        end
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            while (n < vecs[i].n) step();
            chk($sformatf("big_vec%0d", i), {b_hpos, b_vpos, b_hs, b_vs, b_de},
                {vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].vs, vecs[i].de});
        end
        while (n < 2400) step();
        chk_int("hsync_low_cycles", hs_cnt, 96);
        chk_int("hsync_first_hpos", hs_first, 656);
        chk_int("hsync_last_hpos", hs_last, 751);

        // Mid-frame reset on the small raster at (5,3)
        for (int i = 0; i < 200 && !(s_hpos == 5 && s_vpos == 3); i++) step();
        chk_int("reach_small_5_3", int'(s_hpos == 5 && s_vpos == 3), 1);
        reset = 1'b0;
        step();
        chk("big_mid_reset", {b_hpos, b_vpos, b_hs, b_vs, b_de}, {10'd0, 10'd0, 3'b111});
        chk("small_mid_reset", {s_hpos, s_vpos, s_hs, s_vs, s_de}, {10'd0, 10'd0, 3'b001});
        reset = 1'b1;
        step();
        chk("big_after_release", {b_hpos, b_vpos, b_hs, b_vs, b_de}, {10'd1, 10'd0, 3'b111});
        step();
        chk("big_resume", {b_hpos, b_vpos, b_hs, b_vs, b_de}, {10'd2, 10'd0, 3'b111});
        for (int i = 0; i < 320; i++) step();

        checks++;
        if (frames < 12) begin
            errors++;
            $display("FAIL small_frames_seen got %0d want >=12", frames);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
